keypad_event_fifo: RTL and testbench

Downstream stage of keypad_peripheral. Consumes its 8-bit scan code, debounces it, and turns each new key press into a 4-bit key index. Key indices are queued in a small FIFO that the CPU drains through a read strobe, with status and sticky-overflow reporting.

---
 rtl/keypad_event_fifo.sv | 160 ++++++++++++++++
 tb/tb_keypad_event_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_fifo.sv
// Debounces keypad scan codes, turns each new press into a key index and queues it for the CPU.
// Latency: push lands one edge after the debounced code changes; pop data appears the cycle after rd_en. A push into a full queue is dropped and flagged in the sticky overflow bit.
module keypad_event_fifo #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEPTH           = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               scan_code,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);

    // Counter value seen on the edge that completes DEBOUNCE_CYCLES matching samples.
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESSED = 1'b1;

    function automatic logic code_valid(input logic [7:0] c);
        return ($countones(c[7:4]) == 1) && ($countones(c[3:0]) == 1);
    endfunction

    function automatic logic code_idle(input logic [7:0] c);
        return (c[3:0] == 4'h0);
    endfunction

    function automatic logic [3:0] code_index(input logic [7:0] c);
        logic [1:0] col;
        logic [1:0] row;
        col = 2'd0;
        row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (c[4+i]) col = 2'(i);
            if (c[i])   row = 2'(i);
        end
        return {col, row};
    endfunction

    logic [7:0]    candidate;
    logic [7:0]    stable;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            candidate <= 8'h00;
            stable    <= 8'h00;
            db_cnt    <= '0;
        end else if (scan_code != candidate) begin
            candidate <= scan_code;
            db_cnt    <= '0;
        end else begin
            if (db_cnt != CNT_SAT) db_cnt <= db_cnt + 1'b1;
            if (db_cnt == CNT_LOAD) stable <= candidate;
        end
    end

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] pressed_code;
    logic [7:0] pressed_nxt;
    logic       push;
    logic [3:0] push_idx;

    // Invalid stable codes leave both state and the remembered key untouched.
    always_comb begin
        state_nxt   = state;
        pressed_nxt = pressed_code;
        push        = 1'b0;
        push_idx    = code_index(stable);
        case (state)
            ST_IDLE: begin
                if (code_valid(stable)) begin
                    push        = 1'b1;
                    state_nxt   = ST_PRESSED;
                    pressed_nxt = stable;
                end
            end
            ST_PRESSED: begin
                if (code_valid(stable) && (stable != pressed_code)) begin
                    push        = 1'b1;
                    pressed_nxt = stable;
                end else if (code_idle(stable)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pressed_code <= 8'h00;
        end else begin
            state        <= state_nxt;
            pressed_code <= pressed_nxt;
        end
    end

    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            wr;
    logic            drop;
    logic [CNTW-1:0] count_nxt;

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    assign pop  = rd_en && !empty;
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_comb begin
        count_nxt = count;
        if (wr && !pop)      count_nxt = count + 1'b1;
        else if (pop && !wr) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= {4'h0, mem[rd_ptr]};
            end
            rd_valid <= pop;
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == CNTW'(DEPTH));
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Randomized and directed bench for keypad_event_fifo against a queue-based reference model.
module tb_keypad_event_fifo;

    localparam int DB  = 4;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scan_code;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    keypad_event_fifo #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .scan_code(scan_code), .rd_en(rd_en), .ovf_clr(ovf_clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .count(count), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: run length of the sampled code, last debounced code, held key, queue.
    logic [7:0] r_val;
    int         r_len;
    logic [7:0] m_stable;
    logic [7:0] m_key;
    bit         m_held;
    int         q[$];
    bit         m_ovf;
    bit         m_vld;
    logic [7:0] m_data;

    function automatic bit is_valid(input logic [7:0] c);
        return ($countones(c[7:4]) == 1) && ($countones(c[3:0]) == 1);
    endfunction

    function automatic int key_of(input logic [7:0] c);
        int col = 0;
        int row = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[4+i]) col = i;
            if (c[i])   row = i;
        end
        return col * 4 + row;
    endfunction

    function automatic logic [7:0] code_for(input int k);
        logic [7:0] c;
        c = 8'h00;
        c[4 + k / 4] = 1'b1;
        c[k % 4]     = 1'b1;
        return c;
    endfunction

    task automatic model_edge(input logic [7:0] sc, input bit rd, input bit clr, input bit r);
        bit push;
        bit pop;
        int idx;
        if (r) begin
            r_val = 8'h00; r_len = 1; m_stable = 8'h00; m_key = 8'h00; m_held = 0;
            q.delete(); m_ovf = 0; m_vld = 0; m_data = 8'h00;
            return;
        end
        push = 0;
        idx  = 0;
        if (is_valid(m_stable)) begin
            if (!m_held || m_stable != m_key) begin
                push = 1;
                idx  = key_of(m_stable);
            end
            m_held = 1;
            m_key  = m_stable;
        end else if (m_stable[3:0] == 4'h0) begin
            m_held = 0;
        end
        pop   = rd && (q.size() > 0);
        m_vld = pop;
        if (pop) m_data = 8'(q.pop_front());
        if (clr) m_ovf = 0;
        if (push) begin
            if (q.size() < DEP) q.push_back(idx);
            else m_ovf = 1;
        end
        if (sc == r_val) r_len++;
        else begin
            r_val = sc;
            r_len = 1;
        end
        if (r_len == DB) m_stable = r_val;
    endtask

    task automatic check_all();
        chk("rd_valid", rd_valid, m_vld);
        chk("rd_data", rd_data, m_data);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEP);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic [7:0] sc, input bit rd = 0, input bit clr = 0, input bit r = 0);
        scan_code = sc;
        rd_en     = rd;
        ovf_clr   = clr;
        rst       = r;
        @(posedge clk);
        model_edge(sc, rd, clr, r);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [7:0] sc, input int n);
        repeat (n) step(sc);
    endtask

    task automatic press(input int k);
        hold(code_for(k), 5);
        hold(8'h00, 5);
    endtask

    initial begin
        scan_code = 8'h00; rd_en = 0; ovf_clr = 0; rst = 1;
        step(8'h00, 0, 0, 1);
        step(8'h00, 0, 0, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);

        // Single press: latency and read-back.
        hold(8'h84, 4);
        chk("lat_before", count, 0);
        step(8'h84);
        chk("lat_push", count, 1);
        hold(8'h84, 5);
        chk("no_repeat", count, 1);
        hold(8'h00, 6);
        step(8'h00, 1);
        chk("pop_valid", rd_valid, 1);
        chk("pop_data", rd_data, 8'h0E);
        chk("pop_empty", empty, 1);
        step(8'h00, 1);
        chk("empty_pop_valid", rd_valid, 0);
        chk("empty_pop_hold", rd_data, 8'h0E);

        // Bounce must not push.
        step(8'h00, 0, 0, 1);
        hold(8'h84, 2); hold(8'h00, 1); hold(8'h84, 3); hold(8'h00, 1);
        chk("bounce_none", count, 0);
        hold(8'h84, 6);
        chk("bounce_push", count, 1);
        hold(8'h00, 6);
        step(8'h00, 1);
        chk("bounce_data", rd_data, 8'h0E);

        // Overflow: nine presses into an eight-deep queue.
        step(8'h00, 0, 0, 1);
        for (int i = 0; i < 9; i++) press(i);
        chk("ovf_count", count, 8);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            step(8'h00, 1);
            chk("ovf_order", rd_data, i);
        end
        chk("ovf_drained", empty, 1);
        step(8'h00, 0, 1);
        chk("ovf_clr", overflow, 0);

        // Rollover and invalid codes.
        step(8'h00, 0, 0, 1);
        hold(8'h11, 6);
        hold(8'h22, 6);
        chk("roll_count", count, 2);
        hold(8'h33, 10);
        chk("invalid_none", count, 2);
        hold(8'h00, 5);
        step(8'h00, 1);
        chk("roll_first", rd_data, 8'h00);
        step(8'h00, 1);
        chk("roll_second", rd_data, 8'h05);

        // Push and pop together while full.
        step(8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++) press(i);
        hold(code_for(9), 4);
        step(code_for(9), 1);
        chk("pp_count", count, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_data", rd_data, 8'h00);
        hold(8'h00, 5);
        for (int i = 0; i < 8; i++) step(8'h00, 1);

        // Randomized traffic.
        step(8'h00, 0, 0, 1);
        repeat (300) begin
            int kind;
            int len;
            logic [7:0] c;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 8);
            if (kind < 5)      c = code_for($urandom_range(0, 15));
            else if (kind < 8) c = 8'h00;
            else               c = 8'($urandom);
            repeat (len) step(c, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
